// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : flag_unit
//  Description : Status-flag register {S,O,C,Z}, branch-condition evaluator
//                and LIFO save stack for interrupt entry/return.
//                Optional macro FLAG_BYPASS_EN forwards the incoming ALU
//                flags to the condition evaluator in the cycle they are
//                written, so a compare and a branch resolve in one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module flag_unit #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          zero_in,
    input  logic          carry_in,
    input  logic          overflow_in,
    input  logic          sign_in,
    input  logic          we_flags,
    input  logic [2:0]    cond,
    input  logic          push,
    input  logic          pop,
    output logic [3:0]    flags_q,
    output logic          take,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err
);

    // Stack index width; the count needs one extra bit to represent DEPTH.
    localparam int IW = $clog2(DEPTH);

    localparam logic [CW-1:0] c_depth_cnt = CW'(DEPTH);
    localparam logic [CW-1:0] c_zero_cnt  = '0;
    localparam logic [CW-1:0] c_one_cnt   = CW'(1);
    localparam logic [IW-1:0] c_one_idx   = IW'(1);

    // Condition select encodings.
    localparam logic [2:0] c_cond_always = 3'b000;
    localparam logic [2:0] c_cond_z      = 3'b001;
    localparam logic [2:0] c_cond_nz     = 3'b010;
    localparam logic [2:0] c_cond_c      = 3'b011;
    localparam logic [2:0] c_cond_nc     = 3'b100;
    localparam logic [2:0] c_cond_o      = 3'b101;
    localparam logic [2:0] c_cond_s      = 3'b110;
    localparam logic [2:0] c_cond_lt     = 3'b111;

    // Architectural state.
    logic [3:0]    r_flags;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic [3:0]    r_stack [DEPTH];

    // Decoded control.
    logic [3:0]    w_alu_flags;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_misuse;
    logic          w_load_alu;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic [3:0]    w_eval_flags;
    logic          w_take;

    assign w_alu_flags = {sign_in, overflow_in, carry_in, zero_in};

    assign w_full  = (r_count == c_depth_cnt);
    assign w_empty = (r_count == c_zero_cnt);

    // A push or pop is only accepted on its own; asserting both together
    // cancels both so the stack pointer never sees a conflicting update.
    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;

    assign w_misuse = (push & pop)
                    | (push & ~pop & w_full)
                    | (pop & ~push & w_empty);

    // A restored word always wins over fresh ALU flags; otherwise the ALU
    // flags load whenever they are offered (including on rejected pops).
    assign w_load_alu = we_flags & ~w_pop_ok;

    // Writes go to the slot just above the top; pops read the top slot.
    // Low-bit wraparound is harmless: the write index is only used when
    // count < DEPTH and the read index only when count > 0.
    assign w_wr_idx = r_count[IW-1:0];
    assign w_rd_idx = r_count[IW-1:0] - c_one_idx;

`ifdef FLAG_BYPASS_EN
    // Evaluate on the word about to be written so a branch can see it now.
    assign w_eval_flags = w_load_alu ? w_alu_flags : r_flags;
`else
    // Evaluate on the registered word only; no input-to-take path.
    assign w_eval_flags = r_flags;
`endif

    // Branch condition decode over the evaluated {S,O,C,Z} word.
    always_comb begin
        w_take = 1'b0;
        case (cond)
            c_cond_always: w_take = 1'b1;
            c_cond_z:      w_take = w_eval_flags[0];
            c_cond_nz:     w_take = ~w_eval_flags[0];
            c_cond_c:      w_take = w_eval_flags[1];
            c_cond_nc:     w_take = ~w_eval_flags[1];
            c_cond_o:      w_take = w_eval_flags[2];
            c_cond_s:      w_take = w_eval_flags[3];
            c_cond_lt:     w_take = w_eval_flags[3] ^ w_eval_flags[2];
            default:       w_take = 1'b0;
        endcase
    end

    // Flag register: restore from stack, else load ALU flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_pop_ok) begin
            r_flags <= r_stack[w_rd_idx];
        end else if (w_load_alu) begin
            r_flags <= w_alu_flags;
        end
    end

    // Stack occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= c_zero_cnt;
        end else if (w_push_ok) begin
            r_count <= r_count + c_one_cnt;
        end else if (w_pop_ok) begin
            r_count <= r_count - c_one_cnt;
        end
    end

    // Stack storage saves the pre-edge flag word; contents need no reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_stack[w_wr_idx] <= r_flags;
        end
    end

    // Sticky misuse indicator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_misuse) begin
            r_err <= 1'b1;
        end
    end

    assign flags_q = r_flags;
    assign count   = r_count;
    assign full    = w_full;
    assign empty   = w_empty;
    assign err     = r_err;
    assign take    = w_take;

endmodule
`default_nettype wire
